// File: rtl/pid_seq_pkg.sv
// Shared types and constants for the PID loop sequencer.
//   seq_state_t : sequencer FSM states (WAIT, RUN)
//   DATA_W_DEF  : default width of PID din/coeff operands
//   DOUT_W_DEF  : default width of PID duty outputs
//   OVR_MAX     : saturation value of the overrun counter
package pid_seq_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int unsigned DATA_W_DEF = 25;
  localparam int unsigned DOUT_W_DEF = 8;
  localparam logic [7:0]  OVR_MAX    = 8'hFF;

endpackage

// File: rtl/pid_period_timer.sv
// Reloading down-counter that produces the sample tick.
//   HCLK     : clock
//   HRESETn  : synchronous reset, active high
//   enable   : count while high; a rising edge reloads the counter
//   period   : reload value; one tick every period+1 cycles
//   tick     : one-cycle strobe when the counter reaches zero
module pid_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] timer;
  logic                enable_q;
  logic                enable_rise;

  assign enable_rise = enable & ~enable_q;

  // The enable-rise cycle only loads the counter, so a stale count left over
  // from a previous enabled interval can never produce a spurious tick.
  assign tick = enable & ~enable_rise & (timer == '0);

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      timer    <= period;
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (enable_rise || tick) begin
        timer <= period;
      end else if (enable) begin
        timer <= timer - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Autonomous sample-rate controller for the HLS PID_Controller.
// Every period+1 cycles it snapshots the sensor inputs, runs one
// ap_start/ap_ready/ap_done handshake and captures the duty outputs.
//   HCLK, HRESETn      : clock, synchronous active-high reset
//   enable, period     : periodic sampling control
//   init_req, clr_err  : request InitN=0 on next run / clear error status
//   din0_i, din1_i     : live sensor samples
//   ap_start/ready/done: HLS block-level handshake
//   pid_initn          : InitN to the PID core
//   pid_din0, pid_din1 : operands held stable for a whole run
//   dout0_i, dout1_i   : PID duty outputs
//   dout0_o, dout1_o   : captured duty values, result_valid pulses on update
//   busy               : high while a run is in flight
//   overrun_cnt        : saturating count of ticks dropped while busy
//   timeout_err        : sticky watchdog abort flag
module pid_loop_sequencer
  import pid_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DOUT_W   = DOUT_W_DEF,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                init_req,
  input  logic                clr_err,
  input  logic [DATA_W-1:0]   din0_i,
  input  logic [DATA_W-1:0]   din1_i,
  output logic                ap_start,
  input  logic                ap_ready,
  input  logic                ap_done,
  output logic                pid_initn,
  output logic [DATA_W-1:0]   pid_din0,
  output logic [DATA_W-1:0]   pid_din1,
  input  logic [DOUT_W-1:0]   dout0_i,
  input  logic [DOUT_W-1:0]   dout1_i,
  output logic [DOUT_W-1:0]   dout0_o,
  output logic [DOUT_W-1:0]   dout1_o,
  output logic                result_valid,
  output logic                busy,
  output logic [7:0]          overrun_cnt,
  output logic                timeout_err
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_t      state, state_nxt;
  logic            tick;
  logic            snapshot;
  logic            capture;
  logic            abort;
  logic            overrun;
  logic            init_pending;
  logic [WD_W-1:0] wd_cnt;

  pid_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .enable  (enable),
    .period  (period),
    .tick    (tick)
  );

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // ap_done takes priority over the watchdog when both land in the last
  // allowed cycle: the run completed, so its result is kept.
  always_comb begin
    state_nxt = state;
    snapshot  = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    overrun   = 1'b0;
    case (state)
      WAIT: begin
        if (tick) begin
          snapshot  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        overrun = tick;
        if (ap_done) begin
          capture   = 1'b1;
          state_nxt = WAIT;
        end else if (wd_cnt == WD_LAST) begin
          abort     = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      ap_start     <= 1'b0;
      pid_initn    <= 1'b1;
      pid_din0     <= '0;
      pid_din1     <= '0;
      dout0_o      <= '0;
      dout1_o      <= '0;
      result_valid <= 1'b0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
      init_pending <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      result_valid <= capture;

      if (snapshot) begin
        pid_din0     <= din0_i;
        pid_din1     <= din1_i;
        pid_initn    <= ~(init_pending | init_req);
        init_pending <= 1'b0;
        ap_start     <= 1'b1;
        wd_cnt       <= '0;
      end else begin
        if (init_req) begin
          init_pending <= 1'b1;
        end
        if (state == RUN) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
        if (ap_ready || capture || abort) begin
          ap_start <= 1'b0;
        end
      end

      if (capture) begin
        dout0_o   <= dout0_i;
        dout1_o   <= dout1_i;
        pid_initn <= 1'b1;
      end

      if (clr_err) begin
        timeout_err <= 1'b0;
        overrun_cnt <= '0;
      end else begin
        if (abort) begin
          timeout_err <= 1'b1;
        end
        if (overrun && (overrun_cnt != OVR_MAX)) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
module tb_pid_loop_sequencer;

  localparam int unsigned DATA_W   = 25;
  localparam int unsigned DOUT_W   = 8;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned TIMEOUT  = 16;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                init_req;
  logic                clr_err;
  logic [DATA_W-1:0]   din0_i, din1_i;
  logic                ap_start, ap_ready, ap_done;
  logic                pid_initn;
  logic [DATA_W-1:0]   pid_din0, pid_din1;
  logic [DOUT_W-1:0]   dout0_i, dout1_i, dout0_o, dout1_o;
  logic                result_valid, busy, timeout_err;
  logic [7:0]          overrun_cnt;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  pid_loop_sequencer #(
    .DATA_W   (DATA_W),
    .DOUT_W   (DOUT_W),
    .PERIOD_W (PERIOD_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .enable       (enable),
    .period       (period),
    .init_req     (init_req),
    .clr_err      (clr_err),
    .din0_i       (din0_i),
    .din1_i       (din1_i),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .pid_initn    (pid_initn),
    .pid_din0     (pid_din0),
    .pid_din1     (pid_din1),
    .dout0_i      (dout0_i),
    .dout1_i      (dout1_i),
    .dout0_o      (dout0_o),
    .dout1_o      (dout1_o),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    int         c;
  } res_t;

  res_t sb[$];
  int   starts[$];
  logic initns[$];
  int   astart_len[$];
  int   n_results;
  int   cyc = 0;
  int   a_run;
  bit   prev_ap_start;
  logic [DATA_W-1:0] run_din0, run_din1;

  // PID core model
  bit         m_active;
  int         m_age;
  int         ready_dly;
  int         done_lat;
  bit         never_done;
  bit         use_fix;
  logic [7:0] fix_d0, fix_d1;

  // One cycle: sample at the falling edge, check, then drive the PID model.
  task automatic step();
    res_t e;
    bit   rise;
    @(negedge HCLK);
    cyc++;
    rise = (ap_start === 1'b1) && !prev_ap_start;
    if (rise) begin
      starts.push_back(cyc);
      initns.push_back(pid_initn);
      run_din0 = pid_din0;
      run_din1 = pid_din1;
      checks++;
      if (pid_din0 !== din0_i || pid_din1 !== din1_i) begin
        errors++;
        $display("FAIL snapshot @%0d: pid_din=%h/%h required %h/%h",
                 cyc, pid_din0, pid_din1, din0_i, din1_i);
      end
    end else if (busy === 1'b1) begin
      checks++;
      if (pid_din0 !== run_din0 || pid_din1 !== run_din1) begin
        errors++;
        $display("FAIL operand_stable @%0d: pid_din=%h/%h required %h/%h",
                 cyc, pid_din0, pid_din1, run_din0, run_din1);
      end
    end
    if (ap_start === 1'b1) begin
      a_run++;
    end else if (a_run > 0) begin
      astart_len.push_back(a_run);
      a_run = 0;
    end
    if (result_valid === 1'b1) begin
      n_results++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result @%0d: result_valid=1 required 0", cyc);
      end else begin
        e = sb.pop_front();
        if (dout0_o !== e.d0 || dout1_o !== e.d1 || cyc != e.c + 1) begin
          errors++;
          $display("FAIL result @%0d: dout=%h/%h required %h/%h (done @%0d)",
                   cyc, dout0_o, dout1_o, e.d0, e.d1, e.c);
        end
      end
    end
    prev_ap_start = (ap_start === 1'b1);

    if (busy !== 1'b1) m_active = 1'b0;
    if (ap_start === 1'b1 && !m_active) begin
      m_active = 1'b1;
      m_age    = 0;
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (m_active) begin
      if (m_age == ready_dly) ap_ready = 1'b1;
      if (m_age == done_lat && !never_done) begin
        ap_done = 1'b1;
        dout0_i = use_fix ? fix_d0 : 8'($urandom);
        dout1_i = use_fix ? fix_d1 : 8'($urandom);
        sb.push_back('{d0: dout0_i, d1: dout1_i, c: cyc});
        m_active = 1'b0;
      end
      m_age++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_start(input int limit, output int s);
    int n0;
    n0 = starts.size();
    s  = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (starts.size() > n0) begin
        s = starts[starts.size()-1];
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL start_wait: no run start within %0d cycles", limit);
  endtask

  task automatic apply_reset();
    HRESETn  = 1'b1;
    enable   = 1'b0;
    init_req = 1'b0;
    clr_err  = 1'b0;
    step();
    HRESETn = 1'b0;
    sb.delete();
    starts.delete();
    initns.delete();
    astart_len.delete();
    n_results  = 0;
    a_run      = 0;
    ready_dly  = 0;
    done_lat   = 3;
    never_done = 1'b0;
    use_fix    = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ap_start, busy, result_valid, timeout_err, pid_initn} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: start/busy/rv/terr/initn=%b required 00001",
               {ap_start, busy, result_valid, timeout_err, pid_initn});
    end
    checks++;
    if (pid_din0 !== '0 || pid_din1 !== '0 || dout0_o !== '0 || dout1_o !== '0 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: din=%h/%h dout=%h/%h ovr=%0d required all 0",
               pid_din0, pid_din1, dout0_o, dout1_o, overrun_cnt);
    end
  endtask

  task automatic test_periodic();
    int s;
    apply_reset();
    period = 16'd9;
    din0_i = 25'h00123;
    din1_i = 25'h1F0F0;
    enable = 1'b1;
    wait_start(40, s);
    checks++;
    if (pid_din0 !== 25'h00123) begin
      errors++;
      $display("FAIL periodic_din0: %h required 00123", pid_din0);
    end
    run_to(s + 45);
    checks++;
    if (starts.size() != 5) begin
      errors++;
      $display("FAIL periodic_runs: %0d required 5", starts.size());
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != 10) begin
        errors++;
        $display("FAIL periodic_spacing[%0d]: %0d required 10", i, starts[i] - starts[i-1]);
      end
    end
    checks++;
    if (n_results != 5 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL periodic_results: results=%0d ovr=%0d required 5 and 0", n_results, overrun_cnt);
    end
  endtask

  task automatic test_init();
    int   s;
    logic exp_init [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    period = 16'd9;
    enable = 1'b1;
    wait_start(40, s);
    run_to(s + 2);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    run_to(s + 14);
    checks++;
    if (pid_initn !== 1'b1) begin
      errors++;
      $display("FAIL init_restore: pid_initn=%b required 1", pid_initn);
    end
    run_to(s + 29);
    init_req = 1'b1;              // coincident with the tick
    step();
    init_req = 1'b0;
    run_to(s + 41);
    checks++;
    if (initns.size() != 5) begin
      errors++;
      $display("FAIL init_runs: %0d required 5", initns.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (initns[i] !== exp_init[i]) begin
          errors++;
          $display("FAIL init_run[%0d]: pid_initn=%b required %b", i, initns[i], exp_init[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int s, prev, exp_cnt;
    apply_reset();
    period   = 16'd4;
    done_lat = 15;
    enable   = 1'b1;
    wait_start(20, s);
    for (int k = 1; k <= 88; k++) begin
      prev = s;
      wait_start(30, s);
      exp_cnt = (3 * k > 255) ? 255 : 3 * k;
      checks++;
      if (s - prev != 20 || overrun_cnt !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL overrun_run[%0d]: spacing=%0d cnt=%0d required 20 and %0d",
                 k, s - prev, overrun_cnt, exp_cnt);
      end
    end
    run_to(s + 4);
    clr_err = 1'b1;               // same cycle as a dropped tick
    step();
    clr_err = 1'b0;
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL overrun_clear: %0d required 0", overrun_cnt);
    end
    run_to(s + 10);
    checks++;
    if (overrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overrun_after_clear: %0d required 1", overrun_cnt);
    end
  endtask

  task automatic test_timeout();
    int s1, s2, s3;
    logic [7:0] saved;
    apply_reset();
    period = 16'd30;
    enable = 1'b1;
    wait_start(50, s1);
    run_to(s1 + 5);
    saved = dout0_o;
    never_done = 1'b1;
    wait_start(40, s2);
    checks++;
    if (s2 - s1 != 31) begin
      errors++;
      $display("FAIL timeout_spacing: %0d required 31", s2 - s1);
    end
    run_to(s2 + 15);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: terr=%b busy=%b required 0 1", timeout_err, busy);
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || ap_start !== 1'b0 || dout0_o !== saved) begin
      errors++;
      $display("FAIL timeout_abort: terr=%b busy=%b start=%b dout0=%h required 1 0 0 %h",
               timeout_err, busy, ap_start, dout0_o, saved);
    end
    never_done = 1'b0;
    wait_start(40, s3);
    checks++;
    if (s3 - s2 != 31 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_run: spacing=%0d terr=%b required 31 1", s3 - s2, timeout_err);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: terr=%b required 0", timeout_err);
    end
    run_to(s3 + 6);
  endtask

  task automatic test_ready_done_together();
    int s;
    apply_reset();
    period    = 16'd9;
    ready_dly = 2;
    done_lat  = 2;
    use_fix   = 1'b1;
    fix_d0    = 8'hA5;
    fix_d1    = 8'h5A;
    enable    = 1'b1;
    wait_start(40, s);
    run_to(s + 5);
    checks++;
    if (astart_len.size() < 1 || astart_len[0] != 3) begin
      errors++;
      $display("FAIL rdy_done_start_len: %0d required 3",
               (astart_len.size() > 0) ? astart_len[0] : -1);
    end
    checks++;
    if (n_results != 1 || dout0_o !== 8'hA5) begin
      errors++;
      $display("FAIL rdy_done_result: results=%0d dout0=%h required 1 a5", n_results, dout0_o);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset();
    period   = 16'd0;
    done_lat = 0;
    enable   = 1'b1;
    wait_start(10, s);
    run_to(s + 20);
    checks++;
    if (starts.size() != 11) begin
      errors++;
      $display("FAIL b2b_runs: %0d required 11", starts.size());
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != 2) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: %0d required 2", i, starts[i] - starts[i-1]);
      end
    end
    checks++;
    if (n_results != 10 || overrun_cnt !== 8'd10) begin
      errors++;
      $display("FAIL b2b_counts: results=%0d ovr=%0d required 10 10", n_results, overrun_cnt);
    end
  endtask

  task automatic test_enable_fall();
    int s;
    apply_reset();
    period   = 16'd9;
    done_lat = 5;
    enable   = 1'b1;
    wait_start(40, s);
    enable = 1'b0;
    run_to(s + 40);
    checks++;
    if (n_results != 1 || starts.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_fall: results=%0d runs=%0d busy=%b required 1 1 0",
               n_results, starts.size(), busy);
    end
  endtask

  task automatic test_reset_midrun();
    int s;
    apply_reset();
    period   = 16'd9;
    done_lat = 8;
    enable   = 1'b1;
    wait_start(40, s);
    run_to(s + 2);
    HRESETn = 1'b1;
    step();
    HRESETn = 1'b0;
    checks++;
    if ({ap_start, busy, result_valid, timeout_err, pid_initn} !== 5'b00001) begin
      errors++;
      $display("FAIL midrun_reset_flags: start/busy/rv/terr/initn=%b required 00001",
               {ap_start, busy, result_valid, timeout_err, pid_initn});
    end
    checks++;
    if (pid_din0 !== '0 || pid_din1 !== '0 || dout0_o !== '0 || dout1_o !== '0 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset_data: din=%h/%h dout=%h/%h ovr=%0d required all 0",
               pid_din0, pid_din1, dout0_o, dout1_o, overrun_cnt);
    end
    enable = 1'b0;
    run_to(cyc + 12);
    checks++;
    if (n_results != 0) begin
      errors++;
      $display("FAIL midrun_no_result: results=%0d required 0", n_results);
    end
  endtask

  initial begin
    HRESETn  = 1'b1;
    enable   = 1'b0;
    period   = 16'd9;
    init_req = 1'b0;
    clr_err  = 1'b0;
    din0_i   = '0;
    din1_i   = '0;
    dout0_i  = '0;
    dout1_i  = '0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    m_active = 1'b0;
    m_age    = 0;
    prev_ap_start = 1'b0;
    fix_d0 = '0;
    fix_d1 = '0;

    test_reset();
    test_periodic();
    test_init();
    test_overrun();
    test_timeout();
    test_ready_done_together();
    test_back_to_back();
    test_enable_fall();
    test_reset_midrun();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
